dbus_mmio_responder: RTL

DBUS_MMIO_RESPONDER -- requirements
Module: dbus_mmio_responder

---
 rtl/dbus_mmio_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dbus_mmio_responder.sv
// Memory-mapped timer/display register block on the core data bus.
// Optional 64-bit cycle counter at offsets 0x10/0x14 when DBUS_MMIO_CYCLE_CNT_EN is defined.
module dbus_mmio_responder #(
    parameter logic [31:0] TICKS_PER_SEC = 32'd50000000,
    parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        mmio_sel_o,
    output logic        flag1s_o,
    output logic [31:0] display_o,
    output logic        irq_o
);

    localparam logic [5:0] OFF_DISPLAY = 6'h00;
    localparam logic [5:0] OFF_SEC_CNT = 6'h01;
    localparam logic [5:0] OFF_CTRL    = 6'h02;
    localparam logic [5:0] OFF_STATUS  = 6'h03;
`ifdef DBUS_MMIO_CYCLE_CNT_EN
    localparam logic [5:0] OFF_CYC_LO  = 6'h04;
    localparam logic [5:0] OFF_CYC_HI  = 6'h05;
`endif

    logic [31:0] r_display;
    logic [31:0] r_sec_cnt;
    logic        r_tick_en;
    logic        r_irq_en;
    logic        r_pending;
    logic [31:0] r_presc;
    logic [31:0] r_rdata;
    logic        r_sel;
    logic        r_flag;

    logic        w_hit;
    logic [5:0]  w_off;
    logic        w_rd;
    logic        w_wr;
    logic        w_tick;
    logic [31:0] w_rdval;
    logic        w_unused;

    assign w_hit    = (addr_i[31:8] == MMIO_BASE[31:8]);
    assign w_off    = addr_i[7:2];
    assign w_rd     = req_i & ~we_i & w_hit;
    assign w_wr     = req_i & we_i & w_hit;
    assign w_tick   = r_tick_en & (r_presc == TICKS_PER_SEC - 32'd1);
    assign w_unused = &{1'b0, addr_i[1:0]};

`ifdef DBUS_MMIO_CYCLE_CNT_EN
    logic [63:0] r_cycles;
    logic [31:0] r_cyc_hi_latch;

    // High word is captured with the low-word read so the pair stays coherent.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cycles       <= 64'd0;
            r_cyc_hi_latch <= 32'd0;
        end else begin
            r_cycles <= r_cycles + 64'd1;
            if (w_rd && w_off == OFF_CYC_LO)
                r_cyc_hi_latch <= r_cycles[63:32];
        end
    end
`endif

    always_comb begin
        w_rdval = 32'd0;
        case (w_off)
            OFF_DISPLAY: w_rdval = r_display;
            OFF_SEC_CNT: w_rdval = r_sec_cnt;
            OFF_CTRL:    w_rdval = {30'd0, r_irq_en, r_tick_en};
            OFF_STATUS:  w_rdval = {31'd0, r_pending};
`ifdef DBUS_MMIO_CYCLE_CNT_EN
            OFF_CYC_LO:  w_rdval = r_cycles[31:0];
            OFF_CYC_HI:  w_rdval = r_cyc_hi_latch;
`endif
            default:     w_rdval = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_display <= 32'd0;
            r_sec_cnt <= 32'd0;
            r_tick_en <= 1'b1;
            r_irq_en  <= 1'b0;
            r_pending <= 1'b0;
            r_presc   <= 32'd0;
            r_rdata   <= 32'd0;
            r_sel     <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_flag <= w_tick;
            if (!r_tick_en)
                r_presc <= 32'd0;
            else if (w_tick)
                r_presc <= 32'd0;
            else
                r_presc <= r_presc + 32'd1;

            if (w_tick)
                r_sec_cnt <= r_sec_cnt + 32'd1;

            if (w_wr && w_off == OFF_DISPLAY)
                r_display <= wdata_i;

            if (w_wr && w_off == OFF_CTRL) begin
                r_tick_en <= wdata_i[0];
                r_irq_en  <= wdata_i[1];
            end

            // A tick in the same cycle as a clear wins.
            if (w_tick)
                r_pending <= 1'b1;
            else if (w_wr && w_off == OFF_STATUS && wdata_i[0])
                r_pending <= 1'b0;

            r_rdata <= w_rd ? w_rdval : 32'd0;
            r_sel   <= w_rd;
        end
    end

    assign rdata_o    = r_rdata;
    assign mmio_sel_o = r_sel;
    assign flag1s_o   = r_flag;
    assign display_o  = r_display;
    assign irq_o      = r_pending & r_irq_en;

endmodule
